// File: rtl/sync_fifo.sv
// Single-clock VALID/READY FIFO with occupancy count, almost-full/empty flags, flush and registered head.
// Latency: a word written into an empty FIFO appears on rdata_o/rvalid_o one cycle later.
// Backpressure: wready_o drops only when full and reopens one cycle after a read; all outputs come from registers.
// Optional build macro SYNC_FIFO_PEAK_EN enables the high-water-mark register; otherwise peak_o is 0.
module sync_fifo #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 4,
    parameter int AFULL_TH  = (1 << DEPTH) - 1,
    parameter int AEMPTY_TH = 1
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             wvalid_i,
    output logic             wready_o,
    output logic [WIDTH-1:0] rdata_o,
    output logic             rvalid_o,
    input  logic             rready_i,
    output logic [DEPTH:0]   level_o,
    output logic             afull_o,
    output logic             aempty_o,
    output logic [DEPTH:0]   peak_o
);

    localparam int             CAP     = 1 << DEPTH;
    localparam logic [DEPTH:0] CAP_LVL = (DEPTH+1)'(CAP);
    localparam logic [DEPTH:0] AF_LVL  = (DEPTH+1)'(AFULL_TH);
    localparam logic [DEPTH:0] AE_LVL  = (DEPTH+1)'(AEMPTY_TH);
    localparam logic [DEPTH:0] LVL_ONE = (DEPTH+1)'(1);
    localparam logic [DEPTH-1:0] PTR_ONE = DEPTH'(1);

    logic [WIDTH-1:0] mem_q [CAP];
    logic [DEPTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH:0]   level_q, level_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             do_wr, do_rd;

    // Handshakes are judged purely on registered flags; flush cancels both sides.
    assign wready_o = (level_q != CAP_LVL);
    assign rvalid_o = (level_q != '0);
    assign do_wr    = wvalid_i && wready_o && !flush_i;
    assign do_rd    = rvalid_o && rready_i && !flush_i;

    assign level_o  = level_q;
    assign rdata_o  = rdata_q;
    assign afull_o  = (level_q >= AF_LVL);
    assign aempty_o = (level_q <= AE_LVL);

    // Next-state for pointers, level and the head register.
    // The head slot can be the one written this cycle (empty FIFO, or read+write at level 1),
    // in which case the incoming word bypasses the array straight into the head register.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        rdata_d  = rdata_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (do_wr) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (do_rd) rd_ptr_d = rd_ptr_q + PTR_ONE;
            if (do_wr && !do_rd) level_d = level_q + LVL_ONE;
            if (do_rd && !do_wr) level_d = level_q - LVL_ONE;
            if (do_wr && (wr_ptr_q == rd_ptr_d)) rdata_d = wdata_i;
            else                                 rdata_d = mem_q[rd_ptr_d];
        end
    end

    // Storage array: written on accepted writes only, contents need no reset.
    always_ff @(posedge clk_i) begin
        if (do_wr) mem_q[wr_ptr_q] <= wdata_i;
    end

    // Control state and head register; reset outranks flush, which is folded into the _d logic.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            rdata_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            rdata_q  <= rdata_d;
        end
    end

`ifdef SYNC_FIFO_PEAK_EN
    logic [DEPTH:0] peak_q, peak_d;

    // High-water mark tracks the next level; flush leaves it untouched.
    always_comb begin
        peak_d = (level_d > peak_q) ? level_d : peak_q;
    end

    // Peak register, cleared only by reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) peak_q <= '0;
        else         peak_q <= peak_d;
    end

    assign peak_o = peak_q;
`else
    assign peak_o = '0;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo at default parameters (WIDTH=32, DEPTH=4, AFULL_TH=15, AEMPTY_TH=1).
// Inputs change and outputs are sampled 1ns after each rising edge.
// Expected peak depends on whether SYNC_FIFO_PEAK_EN is defined for the build.
module tb_sync_fifo;

    logic        clk = 1'b0;
    logic        reset, flush, wvalid, rready;
    logic [31:0] wdata;
    logic        wready, rvalid, afull, aempty;
    logic [31:0] rdata;
    logic [4:0]  level, peak;

    int vectors    = 0;
    int miscompares = 0;
    logic [31:0] exp_q [$];
    logic [4:0]  exp_peak;

    always #5 clk = ~clk;

    sync_fifo dut (
        .clk_i    (clk),
        .reset_i  (reset),
        .flush_i  (flush),
        .wdata_i  (wdata),
        .wvalid_i (wvalid),
        .wready_o (wready),
        .rdata_o  (rdata),
        .rvalid_o (rvalid),
        .rready_i (rready),
        .level_o  (level),
        .afull_o  (afull),
        .aempty_o (aempty),
        .peak_o   (peak)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] pk(input logic [4:0] v);
`ifdef SYNC_FIFO_PEAK_EN
        return v;
`else
        return 5'd0;
`endif
    endfunction

    task automatic chk_state(input string tag, input logic [4:0] lvl, input logic [4:0] pkv);
        chk({tag, ".level"},  {27'd0, level}, {27'd0, lvl});
        chk({tag, ".rvalid"}, {31'd0, rvalid}, {31'd0, lvl != 5'd0});
        chk({tag, ".wready"}, {31'd0, wready}, {31'd0, lvl != 5'd16});
        chk({tag, ".afull"},  {31'd0, afull},  {31'd0, lvl >= 5'd15});
        chk({tag, ".aempty"}, {31'd0, aempty}, {31'd0, lvl <= 5'd1});
        chk({tag, ".peak"},   {27'd0, peak},   {27'd0, pk(pkv)});
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; wvalid = 1'b0; rready = 1'b0; wdata = '0;
        tick();
        reset = 1'b0;
        chk_state("reset", 5'd0, 5'd0);

        // 1: single write into empty FIFO
        wdata = 32'hA5A5_0001; wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        chk_state("t1", 5'd1, 5'd1);
        chk("t1.rdata", rdata, 32'hA5A5_0001);
        rready = 1'b1;
        tick();
        rready = 1'b0;
        chk_state("t1.drain", 5'd0, 5'd1);

        // 2: fill to capacity, flags along the way, extra write ignored
        for (int i = 0; i < 16; i++) begin
            wdata = i; wvalid = 1'b1;
            tick();
            chk_state("t2.fill", 5'(i + 1), 5'(i + 1));
        end
        chk("t2.head", rdata, 32'd0);
        wdata = 32'd99;
        tick();
        wvalid = 1'b0;
        chk_state("t2.overflow", 5'd16, 5'd16);

        // 3: full with write+read: read only, write lands next cycle
        wdata = 32'd100; wvalid = 1'b1; rready = 1'b1;
        tick();
        chk_state("t3.rdonly", 5'd15, 5'd16);
        chk("t3.rdata1", rdata, 32'd1);
        tick();
        wvalid = 1'b0;
        chk_state("t3.both", 5'd15, 5'd16);
        for (int i = 2; i < 16; i++) exp_q.push_back(i);
        exp_q.push_back(32'd100);
        while (exp_q.size() > 0) begin
            chk("t3.drain", rdata, exp_q.pop_front());
            rready = 1'b1;
            tick();
        end
        rready = 1'b0;
        chk_state("t3.empty", 5'd0, 5'd16);

        // 4: prime 3 words, then 40 cycles of simultaneous read/write
        for (int i = 0; i < 3; i++) begin
            wdata = 1000 + i; wvalid = 1'b1;
            tick();
        end
        rready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            chk("t4.stream", rdata, 32'(1000 + i));
            wdata = 1003 + i;
            tick();
            chk("t4.level", {27'd0, level}, 32'd3);
        end
        wvalid = 1'b0;
        tick();
        tick();
        rready = 1'b0;
        chk_state("t4.lvl1", 5'd1, 5'd16);
        chk("t4.head", rdata, 32'd1042);
        // read+write at level 1: new word becomes head with no bubble
        wdata = 32'd2000; wvalid = 1'b1; rready = 1'b1;
        tick();
        wvalid = 1'b0; rready = 1'b0;
        chk_state("t4.rw1", 5'd1, 5'd16);
        chk("t4.rw1.rdata", rdata, 32'd2000);
        rready = 1'b1;
        tick();
        rready = 1'b0;
        chk_state("t4.empty", 5'd0, 5'd16);

        // 5: flush at level 9 beats a concurrent write and read
        for (int i = 0; i < 9; i++) begin
            wdata = 32'h50 + i; wvalid = 1'b1;
            tick();
        end
        chk_state("t5.pre", 5'd9, 5'd16);
        flush = 1'b1; wdata = 32'hDEAD; rready = 1'b1;
        tick();
        flush = 1'b0; wvalid = 1'b0; rready = 1'b0;
        chk_state("t5.flush", 5'd0, 5'd16);
        wdata = 32'h77; wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        chk_state("t5.after", 5'd1, 5'd16);
        chk("t5.rdata", rdata, 32'h77);

        // 6: reset mid-burst at level 5 clears everything, including peak
        for (int i = 0; i < 4; i++) begin
            wdata = 32'h60 + i; wvalid = 1'b1;
            tick();
        end
        chk_state("t6.pre", 5'd5, 5'd16);
        reset = 1'b1; flush = 1'b1; rready = 1'b1; wdata = 32'hBAD;
        tick();
        reset = 1'b0; flush = 1'b0; wvalid = 1'b0; rready = 1'b0;
        chk_state("t6.reset", 5'd0, 5'd0);
        wdata = 32'h88; wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        chk_state("t6.after", 5'd1, 5'd1);
        chk("t6.rdata", rdata, 32'h88);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
